// File: rtl/multu_seq_pkg.sv
// Shared types and constants for the sequential unsigned multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MULT_W     = 32;
  localparam int MULT_CNT_W = $clog2(MULT_W);

endpackage

// File: rtl/multu_seq_if.sv
// Issue/result bundle between the EX-stage issuer and the multiplier.
interface multu_seq_if import mult_pkg::*; #(
  parameter int WIDTH = MULT_W
);

  logic                 start;
  logic                 flush;
  logic                 accumulate_in;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 busy;
  logic                 last;
  logic                 add_signal;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, flush, accumulate_in, op_a, op_b,
    input  busy, last, add_signal, product
  );

  modport slave (
    input  start, flush, accumulate_in, op_a, op_b,
    output busy, last, add_signal, product
  );

endinterface

// File: rtl/multu_seq_step.sv
// One radix-2 shift-add iteration; purely combinational.
module multu_step import mult_pkg::*; #(
  parameter int WIDTH = MULT_W
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [2*WIDTH-1:0] mplr,
  output logic [2*WIDTH-1:0] acc_nx,
  output logic [2*WIDTH-1:0] mcand_nx,
  output logic [2*WIDTH-1:0] mplr_nx
);

  // conditional add of the multiplicand, then shift both operands
  always_comb begin
    acc_nx   = acc;
    mcand_nx = {mcand[2*WIDTH-2:0], 1'b0};
    mplr_nx  = {1'b0, mplr[2*WIDTH-1:1]};
    if (mplr[0]) begin
      acc_nx = acc + mcand;
    end else begin
      acc_nx = acc;
    end
  end

endmodule

// File: rtl/multu_seq.sv
// Iterative unsigned multiplier (MULTU/MADDU): FSM, counter and datapath registers.
module multu_seq import mult_pkg::*; #(
  parameter int WIDTH = MULT_W
) (
  input  logic        clk,
  input  logic        reset,
  multu_seq_if.slave  bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state_r, state_nx;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   acc_r, mcand_r, mplr_r;
  logic [2*WIDTH-1:0]   acc_nx, mcand_nx, mplr_nx;
  logic [2*WIDTH-1:0]   product_r;
  logic                 acc_flag_r;
  logic                 busy_r, last_r, add_r;
  logic                 load_s, step_s, finish_s;

  multu_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_r),
    .mcand    (mcand_r),
    .mplr     (mplr_r),
    .acc_nx   (acc_nx),
    .mcand_nx (mcand_nx),
    .mplr_nx  (mplr_nx)
  );

  // next-state and datapath control; flush outranks start
  always_comb begin
    state_nx = state_r;
    load_s   = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          state_nx = RUN;
          load_s   = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_nx = IDLE;
        end else begin
          step_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_nx = DONE;
            finish_s = 1'b1;
          end else begin
            state_nx = RUN;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state, datapath and registered outputs; product only moves on entry to DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= {2*WIDTH{1'b0}};
      mcand_r    <= {2*WIDTH{1'b0}};
      mplr_r     <= {2*WIDTH{1'b0}};
      product_r  <= {2*WIDTH{1'b0}};
      acc_flag_r <= 1'b0;
      busy_r     <= 1'b0;
      last_r     <= 1'b0;
      add_r      <= 1'b0;
    end else begin
      state_r <= state_nx;
      if (load_s) begin
        acc_r      <= {2*WIDTH{1'b0}};
        mcand_r    <= {{WIDTH{1'b0}}, bus.op_a};
        mplr_r     <= {{WIDTH{1'b0}}, bus.op_b};
        cnt_r      <= {CNT_W{1'b0}};
        acc_flag_r <= bus.accumulate_in;
      end else if (step_s) begin
        acc_r   <= acc_nx;
        mcand_r <= mcand_nx;
        mplr_r  <= mplr_nx;
        cnt_r   <= cnt_r + CNT_ONE;
      end
      if (finish_s) begin
        product_r <= acc_nx;
      end
      busy_r <= (state_nx != IDLE);
      last_r <= finish_s;
      add_r  <= finish_s & acc_flag_r;
    end
  end

  assign bus.busy       = busy_r;
  assign bus.last       = last_r;
  assign bus.add_signal = add_r;
  assign bus.product    = product_r;

endmodule
